canvas_pixel_streamer: RTL and testbench

Downstream neighbour of the mouse-driven canvas writer. Owns the 784 x 1-bit canvas bitmap RAM (28x28 cells) and accepts the writer's single-bit write port. On a start pulse it streams a consistent snapshot of all pixels, in raster order, to the classifier input over a valid/ready handshake. It also reports ink statistics.

---
 rtl/canvas_pixel_streamer.sv | 156 +++++++++++++++
 tb/tb_canvas_pixel_streamer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/canvas_pixel_streamer.sv
// Canvas bitmap RAM with a write port from the canvas writer and a snapshot streamer
// that emits every pixel in raster order over a valid/ready handshake.
module canvas_pixel_streamer #(
    parameter int unsigned CANVAS_SIZE = 784,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] input_write_addr,
    input  logic              input_write_data,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_pixel,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ink_count,
    output logic              wr_dropped
);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(CANVAS_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    typedef struct packed {
        logic              pixel;
        logic [ADDR_W-1:0] index;
        logic              last;
    } beat_t;

    state_e state_q, state_d;

    logic              mem_q [CANVAS_SIZE];
    logic              rd_data_q;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic              rd_last_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    beat_t             head_q, head_d, sk_q, sk_d, in_beat;
    logic              head_vld_q, head_vld_d, sk_vld_q, sk_vld_d;
    logic [ADDR_W-1:0] ink_q;
    logic              dropped_q;

    logic       start_acc, wr_open, wr_en, pop, rd_en;
    logic [1:0] occ_after;

    assign start_acc = (state_q == StIdle) && start;
    assign wr_open   = (state_q == StIdle) || (state_q == StDone);
    assign wr_en     = write_enable && wr_open && (32'(input_write_addr) < CANVAS_SIZE);
    assign pop       = head_vld_q && out_ready;
    // Occupancy after this edge, counting the read already in flight, so the next read
    // issued now is guaranteed a free slot when its data lands.
    assign occ_after = 2'(head_vld_q) + 2'(sk_vld_q) + 2'(rd_vld_q) - 2'(pop);
    assign rd_en     = (state_q == StFetch) && (occ_after < 2'd2);
    assign in_beat   = '{pixel: rd_data_q, index: rd_idx_q, last: rd_last_q};

    // RAM: writes only while not streaming, so reads never collide with writes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[input_write_addr] <= input_write_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: if (rd_en && (rd_ptr_q == LastIdx)) state_d = StDrain;
            StDrain: if (pop && head_q.last && !sk_vld_q && !rd_vld_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StFetch) || (state_q == StDrain);
        done = (state_q == StDone);
    end

    // Two-entry skid buffer; the head register drives the outputs directly.
    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        sk_d       = sk_q;
        sk_vld_d   = sk_vld_q;
        if (pop || !head_vld_q) begin
            if (sk_vld_q) begin
                head_d     = sk_q;
                head_vld_d = 1'b1;
                sk_d       = in_beat;
                sk_vld_d   = rd_vld_q;
            end else begin
                head_vld_d = rd_vld_q;
                if (rd_vld_q) head_d = in_beat;
            end
        end else if (rd_vld_q) begin
            sk_d     = in_beat;
            sk_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            rd_last_q  <= 1'b0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            sk_q       <= '0;
            sk_vld_q   <= 1'b0;
            ink_q      <= '0;
            dropped_q  <= 1'b0;
        end else begin
            rd_vld_q   <= rd_en;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            sk_q       <= sk_d;
            sk_vld_q   <= sk_vld_d;
            if (rd_en) begin
                rd_idx_q  <= rd_ptr_q;
                rd_last_q <= (rd_ptr_q == LastIdx);
            end
            if (start_acc) begin
                rd_ptr_q  <= '0;
                ink_q     <= '0;
                dropped_q <= 1'b0;
            end else begin
                if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (pop && head_q.pixel) ink_q <= ink_q + 1'b1;
                if (write_enable && busy) dropped_q <= 1'b1;
            end
        end
    end

    assign out_valid  = head_vld_q;
    assign out_pixel  = head_q.pixel;
    assign out_index  = head_q.index;
    assign out_last   = head_q.last;
    assign ink_count  = ink_q;
    assign wr_dropped = dropped_q;

endmodule

// File: tb/tb_canvas_pixel_streamer.sv
// Self-checking bench for canvas_pixel_streamer: a bitmap reference model predicts every
// streamed pixel, the ink total, handshake timing and the write-drop flag.
module tb_canvas_pixel_streamer;
    localparam int N = 784;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       write_enable = 1'b0;
    logic [9:0] input_write_addr = '0;
    logic       input_write_data = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid, out_pixel, out_last, busy, done, wr_dropped;
    logic [9:0] out_index, ink_count;

    bit ref_mem [N];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    canvas_pixel_streamer #(.CANVAS_SIZE(784), .ADDR_W(10)) dut (
        .clk              (clk),
        .rst              (rst),
        .write_enable     (write_enable),
        .input_write_addr (input_write_addr),
        .input_write_data (input_write_data),
        .start            (start),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pixel        (out_pixel),
        .out_index        (out_index),
        .out_last         (out_last),
        .busy             (busy),
        .done             (done),
        .ink_count        (ink_count),
        .wr_dropped       (wr_dropped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ones();
        int s = 0;
        foreach (ref_mem[i]) s += int'(ref_mem[i]);
        return s;
    endfunction

    task automatic wr(input int a, input bit d);
        @(negedge clk);
        write_enable     = 1'b1;
        input_write_addr = 10'(a);
        input_write_data = d;
        if (a < N) ref_mem[a] = d;
        @(posedge clk);
    endtask

    // rnd: random out_ready; timing: check cycle positions; drop_at: cycle of a write to
    // addr 100 while busy; abort_at: handshake count at which reset hits; sw_addr: write
    // of 1 in the same cycle as start.
    task automatic run_stream(input bit rnd, input bit timing, input int drop_at,
                              input int abort_at, input int sw_addr, output bit aborted);
        int          cyc, idx, first, lasths;
        bit          r, stall, got_done;
        logic [12:0] held;
        aborted = 0; idx = 0; first = -1; lasths = -1; stall = 0; got_done = 0; held = '0;
        @(negedge clk);
        start = 1'b1;
        if (sw_addr >= 0) begin
            write_enable     = 1'b1;
            input_write_addr = 10'(sw_addr);
            input_write_data = 1'b1;
            ref_mem[sw_addr] = 1'b1;
        end else begin
            write_enable = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        write_enable = 1'b0;
        check("busy_after_start", busy, 1);
        check("wr_dropped_cleared", wr_dropped, 0);
        check("ink_cleared", ink_count, 0);
        check("no_valid_at_T", out_valid, 0);
        cyc = 0;
        while (cyc < 8000) begin
            if (stall) check("stall_hold", {out_valid, out_last, out_pixel, out_index}, held);
            if (out_valid && first < 0) first = cyc;
            if (done) begin
                got_done = 1;
                break;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b0;
                #1;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_ink", ink_count, 0);
                check("abort_done", done, 0);
                @(negedge clk);
                rst = 1'b1;
                out_ready = 1'b0;
                write_enable = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check("abort_no_done", done, 0);
                aborted = 1;
                return;
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready        = r;
            start            = (cyc == 5);
            write_enable     = (cyc == drop_at);
            input_write_addr = 10'd100;
            input_write_data = 1'b1;
            if (out_valid && r) begin
                if (idx < N) begin
                    check("index", out_index, idx);
                    check("pixel", out_pixel, ref_mem[idx]);
                    check("last", out_last, idx == N - 1);
                end else begin
                    check("extra_pixel", idx, N - 1);
                end
                if (idx == N - 1) lasths = cyc;
                idx++;
            end
            stall = out_valid && !r;
            held  = {out_valid, out_last, out_pixel, out_index};
            @(negedge clk);
            cyc++;
        end
        write_enable = 1'b0;
        check("done_seen", got_done, 1);
        check("handshake_count", idx, N);
        check("ink_count", ink_count, ones());
        check("busy_in_done", busy, 0);
        check("valid_in_done", out_valid, 0);
        if (timing) begin
            check("first_valid_cycle", first, 2);
            check("last_cycle", lasths, N + 1);
            check("done_cycle", cyc, N + 2);
        end
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        @(negedge clk);
        check("start_in_done_ignored", busy, 0);
        check("ink_held", ink_count, ones());
    endtask

    initial begin
        bit ab;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dropped", wr_dropped, 0);
        check("rst_ink", ink_count, 0);
        check("rst_index", out_index, 0);
        check("rst_last", out_last, 0);
        check("rst_pixel", out_pixel, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) wr(i, 1'b0);

        wr(0, 1'b1); wr(29, 1'b1); wr(783, 1'b1);
        run_stream(1'b0, 1'b1, -1, -1, -1, ab);
        check("ink_three", ink_count, 3);
        run_stream(1'b1, 1'b0, -1, -1, -1, ab);
        check("ink_three_stalled", ink_count, 3);

        run_stream(1'b1, 1'b0, 10, -1, -1, ab);
        check("wr_dropped_set", wr_dropped, 1);
        wr(100, 1'b1);
        run_stream(1'b0, 1'b1, -1, -1, -1, ab);
        check("wr_dropped_after_restart", wr_dropped, 0);
        check("ink_four", ink_count, 4);

        wr(800, 1'b1);
        run_stream(1'b1, 1'b0, -1, -1, -1, ab);
        check("oob_no_drop", wr_dropped, 0);

        run_stream(1'b0, 1'b1, -1, -1, 500, ab);

        repeat (2) begin
            for (int i = 0; i < N; i++) wr(i, 1'($urandom_range(0, 1)));
            run_stream(1'b1, 1'b0, -1, -1, -1, ab);
        end

        run_stream(1'b0, 1'b0, -1, 400, -1, ab);
        check("aborted", ab, 1);
        run_stream(1'b0, 1'b1, -1, -1, -1, ab);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
